// File: rtl/vx_ram_port_ctrl.sv
// Request/response front-end for a single-port RAM with 1-cycle read latency.
// Reads are credit-limited to RSP_DEPTH in flight so the response FIFO never overflows.
module vx_ram_port_ctrl #(
  parameter int DATAW     = 32,
  parameter int SIZE      = 256,
  parameter int BYTEENW   = 4,
  parameter int ADDRW     = $clog2(SIZE),
  parameter int TAGW      = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  input  logic               req_rw,
  input  logic [ADDRW-1:0]   req_addr,
  input  logic [BYTEENW-1:0] req_byteen,
  input  logic [DATAW-1:0]   req_data,
  input  logic [TAGW-1:0]    req_tag,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic [DATAW-1:0]   rsp_data,
  output logic [TAGW-1:0]    rsp_tag,
  input  logic               rsp_ready,
  output logic               ram_en,
  output logic [ADDRW-1:0]   ram_addr,
  output logic [BYTEENW-1:0] ram_wren,
  output logic [DATAW-1:0]   ram_wdata,
  input  logic [DATAW-1:0]   ram_rdata
);

  localparam int CNTW = $clog2(RSP_DEPTH + 1);
  localparam int PTRW = $clog2(RSP_DEPTH);

  if (RSP_DEPTH < 2 || SIZE < 2 || SIZE > (1 << ADDRW) ||
      !(BYTEENW == 1 || (BYTEENW % 4 == 0 && DATAW == 8 * BYTEENW))) begin : g_bad_params
    $error("vx_ram_port_ctrl: illegal parameter combination");
  end

  logic [CNTW-1:0]  outstanding_q, outstanding_d;
  logic             pending_q;
  logic [TAGW-1:0]  ptag_q;
  logic [PTRW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [DATAW-1:0] fifo_data_q [RSP_DEPTH];
  logic [TAGW-1:0]  fifo_tag_q  [RSP_DEPTH];

  logic fire, read_fire, push, pop;

  assign req_ready = (outstanding_q < CNTW'(RSP_DEPTH));
  // Gating with reset_n keeps the RAM port idle while reset is held.
  assign fire      = reset_n & req_valid & req_ready;
  assign read_fire = fire & ~req_rw;

  assign ram_en    = fire;
  assign ram_addr  = req_addr;
  assign ram_wren  = (fire && req_rw) ? req_byteen : '0;
  assign ram_wdata = req_data;

  assign push      = pending_q;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = fifo_data_q[rptr_q];
  assign rsp_tag   = fifo_tag_q[rptr_q];

  always_comb begin
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    case ({read_fire, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push) wptr_d = (wptr_q == PTRW'(RSP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PTRW'(RSP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
      pending_q     <= 1'b0;
      ptag_q        <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      pending_q     <= read_fire;
      if (read_fire) ptag_q <= req_tag;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wptr_q] <= ram_rdata;
      fifo_tag_q[wptr_q]  <= ptag_q;
    end
  end

endmodule
